// File: rtl/banner_scroller_if.sv
// Purpose: control, message-write and display signals of the banner scroller.
// Latency: none, this is wiring only.
// Backpressure: none. Writes and steps are single-cycle strobes that are always accepted.
interface banner_scroller_if #(
    parameter int DIGITS  = 6,
    parameter int MSG_LEN = 16,
    parameter int SYM_W   = 5
);
    localparam int AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

    logic                      en;
    logic                      dir;
    logic [1:0]                mode;
    logic                      restart;
    logic                      wr_en;
    logic [AW-1:0]             wr_addr;
    logic [SYM_W-1:0]          wr_data;
    logic [DIGITS*SYM_W-1:0]   disp;
    logic [AW-1:0]             pos;
    logic                      wrap;
    logic                      done;

    // The controller drives the controls and message writes.
    modport master (
        output en, dir, mode, restart, wr_en, wr_addr, wr_data,
        input  disp, pos, wrap, done
    );

    // The scroller receives the controls and drives the window.
    modport slave (
        input  en, dir, mode, restart, wr_en, wr_addr, wr_data,
        output disp, pos, wrap, done
    );
endinterface

// File: rtl/banner_scroller.sv
// Purpose: scrolls a DIGITS-wide window over a writable MSG_LEN-symbol message (rotate/bounce/single-shot/hold).
// Latency: disp is combinational from registered pos/msg; pos/wrap/done update on the edge ending a step cycle.
// Backpressure: none. Optional macro BANNER_DWELL_EN makes rotate mode pause DWELL steps at pos 0.
module banner_scroller #(
    parameter int DIGITS   = 6,
    parameter int MSG_LEN  = 16,
    parameter int SYM_W    = 5,
    parameter int TICK_DIV = 15_000_000,
    parameter int DWELL    = 4
) (
    input logic               clk,
    input logic               rst_n,
    banner_scroller_if.slave  bus
);
    localparam int AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [CW-1:0] TLAST     = CW'(TICK_DIV - 1);
    localparam logic [AW-1:0] LAST      = AW'(MSG_LEN - 1);
    localparam logic [AW-1:0] LIM       = AW'(MSG_LEN - DIGITS);
    localparam logic [AW-1:0] ONE       = AW'(1);
    localparam logic [AW:0]   MSG_LEN_W = (AW+1)'(MSG_LEN);

    localparam logic [1:0] M_ROT  = 2'b00;
    localparam logic [1:0] M_BNC  = 2'b01;
    localparam logic [1:0] M_SGL  = 2'b10;

    logic [CW-1:0]    cnt_q;
    logic             step;
    logic [AW-1:0]    pos_q, pos_nxt, rot_nxt;
    logic             up_q, up_nxt;
    logic             done_q, done_nxt;
    logic             wrap_q, wrap_nxt;
    logic [1:0]       mode_q;
    logic [SYM_W-1:0] msg [MSG_LEN];
    logic             wr_ok;
    logic [DIGITS*SYM_W-1:0] disp_w;
    int               idx;

`ifdef BANNER_DWELL_EN
    localparam int DWW = (DWELL > 0) ? $clog2(DWELL + 1) : 1;
    logic [DWW-1:0] dwell_q, dwell_nxt;
`endif

    // A step happens on the last count of each enabled tick period.
    assign step  = bus.en && (cnt_q == TLAST);
    assign wr_ok = bus.wr_en && ({1'b0, bus.wr_addr} < MSG_LEN_W);

    // Tick divider: counts while enabled, freezes otherwise, cleared by restart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (bus.restart) begin
            cnt_q <= '0;
        end else if (bus.en) begin
            cnt_q <= step ? '0 : cnt_q + 1'b1;
        end
    end

    // Message store: reset to an ascending hex pattern, out-of-range writes dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                msg[i] <= SYM_W'(i % 16);
            end
        end else if (wr_ok) begin
            msg[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Circular neighbour of pos in the selected rotate direction.
    always_comb begin
        rot_nxt = pos_q;
        if (bus.dir) begin
            rot_nxt = (pos_q == LAST) ? '0 : pos_q + ONE;
        end else begin
            rot_nxt = (pos_q == '0) ? LAST : pos_q - ONE;
        end
    end

    // Per-mode position update; restart wins over any coincident step.
    always_comb begin
        pos_nxt  = pos_q;
        up_nxt   = up_q;
        done_nxt = done_q;
        wrap_nxt = 1'b0;
`ifdef BANNER_DWELL_EN
        dwell_nxt = dwell_q;
`endif
        // Leaving or entering a mode forgets a finished single-shot.
        if (bus.mode != mode_q) begin
            done_nxt = 1'b0;
        end
        if (step) begin
`ifdef BANNER_DWELL_EN
            // A pause only makes sense while rotating; drop it elsewhere.
            if (bus.mode != M_ROT) begin
                dwell_nxt = '0;
            end
`endif
            case (bus.mode)
                M_ROT: begin
`ifdef BANNER_DWELL_EN
                    if (dwell_q != '0) begin
                        dwell_nxt = dwell_q - 1'b1;
                    end else begin
                        pos_nxt = rot_nxt;
                        if (rot_nxt == '0 && pos_q != '0) begin
                            dwell_nxt = DWW'(DWELL);
                        end
                    end
`else
                    pos_nxt = rot_nxt;
`endif
                    wrap_nxt = (pos_nxt == '0) && (pos_q != '0);
                end
                M_BNC: begin
                    if (LIM == '0) begin
                        pos_nxt = '0;
                    end else if (pos_q > LIM) begin
                        // Outside the bounce range: head back down into it.
                        up_nxt  = 1'b0;
                        pos_nxt = pos_q - ONE;
                    end else if (up_q) begin
                        if (pos_q == LIM) begin
                            pos_nxt = pos_q - ONE;
                            up_nxt  = 1'b0;
                        end else begin
                            pos_nxt = pos_q + ONE;
                            if ((pos_q + ONE) == LIM) up_nxt = 1'b0;
                        end
                    end else begin
                        if (pos_q == '0) begin
                            pos_nxt = ONE;
                            up_nxt  = 1'b1;
                        end else begin
                            pos_nxt = pos_q - ONE;
                            if (pos_q == ONE) up_nxt = 1'b1;
                        end
                    end
                end
                M_SGL: begin
                    if (pos_q < LIM) begin
                        pos_nxt = pos_q + ONE;
                        if ((pos_q + ONE) == LIM) done_nxt = 1'b1;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
                default: begin
                    // Hold: position frozen, divider keeps running.
                end
            endcase
        end
        if (bus.restart) begin
            pos_nxt  = '0;
            up_nxt   = 1'b1;
            done_nxt = 1'b0;
            wrap_nxt = 1'b0;
`ifdef BANNER_DWELL_EN
            dwell_nxt = '0;
`endif
        end
    end

    // Scroll state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q  <= '0;
            up_q   <= 1'b1;
            done_q <= 1'b0;
            wrap_q <= 1'b0;
            mode_q <= M_ROT;
`ifdef BANNER_DWELL_EN
            dwell_q <= '0;
`endif
        end else begin
            pos_q  <= pos_nxt;
            up_q   <= up_nxt;
            done_q <= done_nxt;
            wrap_q <= wrap_nxt;
            mode_q <= bus.mode;
`ifdef BANNER_DWELL_EN
            dwell_q <= dwell_nxt;
`endif
        end
    end

    // Window: digit i shows msg[(pos + DIGITS-1-i) mod MSG_LEN]; the sum is below 2*MSG_LEN.
    always_comb begin
        disp_w = '0;
        idx    = 0;
        for (int i = 0; i < DIGITS; i++) begin
            idx = int'(pos_q) + DIGITS - 1 - i;
            if (idx >= MSG_LEN) idx = idx - MSG_LEN;
            disp_w[i*SYM_W +: SYM_W] = msg[idx[AW-1:0]];
        end
    end

    assign bus.disp = disp_w;
    assign bus.pos  = pos_q;
    assign bus.wrap = wrap_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_banner_scroller.sv
// Directed bench for banner_scroller with DIGITS=6, MSG_LEN=8, TICK_DIV=4, DWELL=4.
// A second 7-symbol instance exercises out-of-range write addresses.
// Inputs change 1 ns after a rising edge; outputs are checked at that point.
module tb_banner_scroller;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    banner_scroller_if #(.DIGITS(6), .MSG_LEN(8), .SYM_W(5)) bif ();
    banner_scroller_if #(.DIGITS(6), .MSG_LEN(7), .SYM_W(5)) bif7 ();

    banner_scroller #(.DIGITS(6), .MSG_LEN(8), .SYM_W(5), .TICK_DIV(4), .DWELL(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    banner_scroller #(.DIGITS(6), .MSG_LEN(7), .SYM_W(5), .TICK_DIV(4), .DWELL(4)) dut7 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [29:0] d6(input logic [4:0] a, b, c, d, e, f);
        return {a, b, c, d, e, f};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_restart();
        bif.restart = 1'b1;
        cyc(1);
        bif.restart = 1'b0;
    endtask

    task automatic test_reset();
        cyc(3);
        total++; if (bif.pos !== 3'd0) begin bad++; $display("FAIL reset_pos got=%0d want=0", bif.pos); end
        total++; if (bif.wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap got=%b want=0", bif.wrap); end
        total++; if (bif.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bif.done); end
        total++; if (bif.disp !== d6(0, 1, 2, 3, 4, 5)) begin bad++; $display("FAIL reset_disp got=%h want=%h", bif.disp, d6(0, 1, 2, 3, 4, 5)); end
        total++; if (bif7.disp !== d6(0, 1, 2, 3, 4, 5)) begin bad++; $display("FAIL reset_disp7 got=%h want=%h", bif7.disp, d6(0, 1, 2, 3, 4, 5)); end
        rst_n = 1'b1;
    endtask

    task automatic test_rotate();
        bif.mode = 2'b00; bif.dir = 1'b1; bif.en = 1'b1;
        cyc(3);
        total++; if (bif.pos !== 3'd0) begin bad++; $display("FAIL rot_prestep got=%0d want=0", bif.pos); end
        cyc(1);
        total++; if (bif.pos !== 3'd1) begin bad++; $display("FAIL rot_step1 got=%0d want=1", bif.pos); end
        total++; if (bif.disp !== d6(1, 2, 3, 4, 5, 6)) begin bad++; $display("FAIL rot_disp1 got=%h want=%h", bif.disp, d6(1, 2, 3, 4, 5, 6)); end
        cyc(24);
        total++; if (bif.pos !== 3'd7) begin bad++; $display("FAIL rot_pos7 got=%0d want=7", bif.pos); end
        total++; if (bif.wrap !== 1'b0) begin bad++; $display("FAIL rot_nowrap got=%b want=0", bif.wrap); end
        cyc(4);
        total++; if (bif.pos !== 3'd0) begin bad++; $display("FAIL rot_wrap_pos got=%0d want=0", bif.pos); end
        total++; if (bif.wrap !== 1'b1) begin bad++; $display("FAIL rot_wrap_pulse got=%b want=1", bif.wrap); end
        cyc(1);
        total++; if (bif.wrap !== 1'b0) begin bad++; $display("FAIL rot_wrap_once got=%b want=0", bif.wrap); end
    endtask

    // Continues from the wrap: the divider is one cycle into its period.
    task automatic test_dwell();
        cyc(3);
`ifdef BANNER_DWELL_EN
        total++; if (bif.pos !== 3'd0) begin bad++; $display("FAIL dwell_step1 got=%0d want=0", bif.pos); end
        cyc(12);
        total++; if (bif.pos !== 3'd0) begin bad++; $display("FAIL dwell_step4 got=%0d want=0", bif.pos); end
        total++; if (bif.wrap !== 1'b0) begin bad++; $display("FAIL dwell_wrap got=%b want=0", bif.wrap); end
        cyc(4);
        total++; if (bif.pos !== 3'd1) begin bad++; $display("FAIL dwell_release got=%0d want=1", bif.pos); end
`else
        total++; if (bif.pos !== 3'd1) begin bad++; $display("FAIL nodwell_move got=%0d want=1", bif.pos); end
`endif
    endtask

    task automatic test_dir_right();
        bif.dir = 1'b0;
        do_restart();
        total++; if (bif.pos !== 3'd0) begin bad++; $display("FAIL right_restart got=%0d want=0", bif.pos); end
        cyc(4);
        total++; if (bif.pos !== 3'd7) begin bad++; $display("FAIL right_pos got=%0d want=7", bif.pos); end
        total++; if (bif.disp !== d6(7, 0, 1, 2, 3, 4)) begin bad++; $display("FAIL right_disp got=%h want=%h", bif.disp, d6(7, 0, 1, 2, 3, 4)); end
        total++; if (bif.wrap !== 1'b0) begin bad++; $display("FAIL right_wrap got=%b want=0", bif.wrap); end
        cyc(4);
        total++; if (bif.pos !== 3'd6) begin bad++; $display("FAIL right_pos6 got=%0d want=6", bif.pos); end
    endtask

    task automatic test_bounce();
        logic [2:0] exp_b [5];
        exp_b = '{3'd1, 3'd2, 3'd1, 3'd0, 3'd1};
        bif.mode = 2'b01; bif.dir = 1'b1;
        do_restart();
        for (int k = 0; k < 5; k++) begin
            cyc(4);
            total++; if (bif.pos !== exp_b[k]) begin bad++; $display("FAIL bounce_step%0d got=%0d want=%0d", k + 1, bif.pos, exp_b[k]); end
        end
    endtask

    task automatic test_single();
        bif.mode = 2'b10;
        do_restart();
        total++; if (bif.done !== 1'b0) begin bad++; $display("FAIL single_start_done got=%b want=0", bif.done); end
        cyc(4);
        total++; if (bif.pos !== 3'd1 || bif.done !== 1'b0) begin bad++; $display("FAIL single_s1 got pos=%0d done=%b want pos=1 done=0", bif.pos, bif.done); end
        cyc(4);
        total++; if (bif.pos !== 3'd2 || bif.done !== 1'b1) begin bad++; $display("FAIL single_s2 got pos=%0d done=%b want pos=2 done=1", bif.pos, bif.done); end
        cyc(4);
        total++; if (bif.pos !== 3'd2 || bif.done !== 1'b1) begin bad++; $display("FAIL single_stop got pos=%0d done=%b want pos=2 done=1", bif.pos, bif.done); end
        bif.mode = 2'b00;
        cyc(1);
        total++; if (bif.done !== 1'b0) begin bad++; $display("FAIL single_modechg got=%b want=0", bif.done); end
        total++; if (bif.pos !== 3'd2) begin bad++; $display("FAIL single_modechg_pos got=%0d want=2", bif.pos); end
    endtask

    task automatic test_write_step();
        bif.dir = 1'b1; bif.mode = 2'b00;
        do_restart();
        cyc(3);
        bif.wr_en = 1'b1; bif.wr_addr = 3'd3; bif.wr_data = 5'h1A;
        cyc(1);
        bif.wr_en = 1'b0;
        total++; if (bif.pos !== 3'd1) begin bad++; $display("FAIL wrstep_pos got=%0d want=1", bif.pos); end
        total++; if (bif.disp !== d6(1, 2, 5'h1A, 4, 5, 6)) begin bad++; $display("FAIL wrstep_disp got=%h want=%h", bif.disp, d6(1, 2, 5'h1A, 4, 5, 6)); end
    endtask

    task automatic test_freeze();
        cyc(2);
        bif.en = 1'b0;
        cyc(10);
        total++; if (bif.pos !== 3'd1) begin bad++; $display("FAIL freeze_pos got=%0d want=1", bif.pos); end
        bif.en = 1'b1;
        cyc(1);
        total++; if (bif.pos !== 3'd1) begin bad++; $display("FAIL freeze_resume got=%0d want=1", bif.pos); end
        cyc(1);
        total++; if (bif.pos !== 3'd2) begin bad++; $display("FAIL freeze_step got=%0d want=2", bif.pos); end
        cyc(3);
        bif.restart = 1'b1;
        cyc(1);
        bif.restart = 1'b0;
        total++; if (bif.pos !== 3'd0) begin bad++; $display("FAIL restart_step got=%0d want=0", bif.pos); end
        cyc(3);
        total++; if (bif.pos !== 3'd0) begin bad++; $display("FAIL restart_cnt got=%0d want=0", bif.pos); end
        cyc(1);
        total++; if (bif.pos !== 3'd1) begin bad++; $display("FAIL restart_next got=%0d want=1", bif.pos); end
    endtask

    task automatic test_hold();
        bif.mode = 2'b11;
        cyc(8);
        total++; if (bif.pos !== 3'd1) begin bad++; $display("FAIL hold_pos got=%0d want=1", bif.pos); end
        bif.mode = 2'b00;
        cyc(4);
        total++; if (bif.pos !== 3'd2) begin bad++; $display("FAIL hold_release got=%0d want=2", bif.pos); end
    endtask

    task automatic test_bad_addr();
        bif7.wr_en = 1'b1; bif7.wr_addr = 3'd7; bif7.wr_data = 5'h1F;
        cyc(1);
        total++; if (bif7.disp !== d6(0, 1, 2, 3, 4, 5)) begin bad++; $display("FAIL badaddr_ignored got=%h want=%h", bif7.disp, d6(0, 1, 2, 3, 4, 5)); end
        bif7.wr_addr = 3'd5;
        cyc(1);
        bif7.wr_en = 1'b0;
        total++; if (bif7.disp !== d6(0, 1, 2, 3, 4, 5'h1F)) begin bad++; $display("FAIL lastaddr_write got=%h want=%h", bif7.disp, d6(0, 1, 2, 3, 4, 5'h1F)); end
    endtask

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0;
        bif.en = 1'b0; bif.dir = 1'b1; bif.mode = 2'b00; bif.restart = 1'b0;
        bif.wr_en = 1'b0; bif.wr_addr = '0; bif.wr_data = '0;
        bif7.en = 1'b0; bif7.dir = 1'b1; bif7.mode = 2'b00; bif7.restart = 1'b0;
        bif7.wr_en = 1'b0; bif7.wr_addr = '0; bif7.wr_data = '0;
        test_reset();
        test_rotate();
        test_dwell();
        test_dir_right();
        test_bounce();
        test_single();
        test_write_step();
        test_freeze();
        test_hold();
        test_bad_addr();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
